// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch-PC generator, in-order pending-request tracker
// that discards stale responses after a redirect, and an instruction buffer feeding ID.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter int unsigned EBUS_W          = 16,
  parameter int unsigned EBUS_ADEF       = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic                inst_sram_req,
  output logic                inst_sram_wr,
  output logic [1:0]          inst_sram_size,
  output logic [31:0]         inst_sram_addr,
  output logic [3:0]          inst_sram_wstrb,
  output logic [31:0]         inst_sram_wdata,
  input  logic                inst_sram_addr_ok,
  input  logic                inst_sram_data_ok,
  input  logic [31:0]         inst_sram_rdata,
  input  logic                br_taken,
  input  logic [31:0]         br_target,
  input  logic                flush,
  input  logic [31:0]         flush_target,
  input  logic                id_allow_in,
  output logic                ifreg_valid,
  output logic [EBUS_W+63:0]  ifreg_bus
);

  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned IW  = $clog2(IBUF_DEPTH);
  localparam int unsigned ICW = IW + 1;
  localparam int unsigned BW  = EBUS_W + 64;
  localparam logic [EBUS_W-1:0] ADEF_VEC = EBUS_W'(1) << EBUS_ADEF;

  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    pend_pc_q [MAX_OUTSTANDING];
  logic [31:0]    pend_pc_d [MAX_OUTSTANDING];
  logic [PW-1:0]  pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [CW-1:0]  pend_cnt_q, pend_cnt_d;
  logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [BW-1:0]  ibuf_q [IBUF_DEPTH];
  logic [BW-1:0]  ibuf_d [IBUF_DEPTH];
  logic [IW-1:0]  ibuf_rd_q, ibuf_rd_d, ibuf_wr_q, ibuf_wr_d;
  logic [ICW-1:0] ibuf_cnt_q, ibuf_cnt_d;
  logic           adef_hold_q, adef_hold_d;

  logic           redirect;
  logic [31:0]    redirect_pc;
  logic           misaligned;
  logic           ibuf_push, ibuf_pop;
  logic [BW-1:0]  ibuf_entry;

  function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wstrb = '0;
  assign inst_sram_wdata = '0;

  always_comb begin
    redirect      = flush | br_taken;
    redirect_pc   = flush ? flush_target : br_target;
    misaligned    = fetch_pc_q[1:0] != 2'b00;
    // Buffer credit counts in-flight requests, so a returning response always has a slot.
    inst_sram_req = ~reset & ~redirect & ~adef_hold_q & ~misaligned
                  & ((32'(pend_cnt_q) + 32'(drop_cnt_q)) < MAX_OUTSTANDING)
                  & ((32'(ibuf_cnt_q) + 32'(pend_cnt_q)) < IBUF_DEPTH);
    ifreg_valid   = (ibuf_cnt_q != '0) & ~redirect;
    ifreg_bus     = ibuf_q[ibuf_rd_q];
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pend_pc_d   = pend_pc_q;
    pend_rd_d   = pend_rd_q;
    pend_wr_d   = pend_wr_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ibuf_d      = ibuf_q;
    ibuf_rd_d   = ibuf_rd_q;
    ibuf_wr_d   = ibuf_wr_q;
    adef_hold_d = adef_hold_q;
    ibuf_push   = 1'b0;
    ibuf_entry  = '0;
    ibuf_pop    = ifreg_valid & id_allow_in;

    if (inst_sram_req & inst_sram_addr_ok) begin
      pend_pc_d[pend_wr_q] = fetch_pc_q;
      pend_wr_d            = pend_inc(pend_wr_q);
      pend_cnt_d           = pend_cnt_d + CW'(1);
      fetch_pc_d           = fetch_pc_q + 32'd4;
    end

    if (inst_sram_data_ok) begin
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else if (pend_cnt_q != '0) begin
        pend_rd_d  = pend_inc(pend_rd_q);
        pend_cnt_d = pend_cnt_d - CW'(1);
        ibuf_push  = 1'b1;
        ibuf_entry = {{EBUS_W{1'b0}}, inst_sram_rdata, pend_pc_q[pend_rd_q]};
      end
    end

    if (misaligned & ~adef_hold_q & (pend_cnt_q == '0) & (32'(ibuf_cnt_q) < IBUF_DEPTH)) begin
      ibuf_push   = 1'b1;
      ibuf_entry  = {ADEF_VEC, 32'h0, fetch_pc_q};
      adef_hold_d = 1'b1;
    end

    if (ibuf_push) begin
      ibuf_d[ibuf_wr_q] = ibuf_entry;
      ibuf_wr_d         = ibuf_wr_q + IW'(1);
    end
    if (ibuf_pop) begin
      ibuf_rd_d = ibuf_rd_q + IW'(1);
    end
    ibuf_cnt_d = ibuf_cnt_q + ICW'(ibuf_push) - ICW'(ibuf_pop);

    // Redirect applies after this cycle's response bookkeeping: every response
    // still owed for a pending PC becomes a drop.
    if (redirect) begin
      fetch_pc_d  = redirect_pc;
      drop_cnt_d  = drop_cnt_d + pend_cnt_d;
      pend_cnt_d  = '0;
      pend_rd_d   = '0;
      pend_wr_d   = '0;
      ibuf_cnt_d  = '0;
      ibuf_rd_d   = '0;
      ibuf_wr_d   = '0;
      adef_hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      pend_rd_q   <= '0;
      pend_wr_q   <= '0;
      pend_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      ibuf_rd_q   <= '0;
      ibuf_wr_q   <= '0;
      ibuf_cnt_q  <= '0;
      adef_hold_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_rd_q   <= pend_rd_d;
      pend_wr_q   <= pend_wr_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      ibuf_rd_q   <= ibuf_rd_d;
      ibuf_wr_q   <= ibuf_wr_d;
      ibuf_cnt_q  <= ibuf_cnt_d;
      adef_hold_q <= adef_hold_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
    ibuf_q    <= ibuf_d;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, directed corner sequences, and
// randomized traffic against a queue-based reference model and an in-order memory model.
module tb_if_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int MAXO  = 2;
  localparam int DEPTH = 4;
  localparam logic [15:0] ADEF_VEC = 16'h0100;

  logic        clk, reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        br_taken, flush, id_allow_in, ifreg_valid;
  logic [31:0] br_target, flush_target;
  logic [79:0] ifreg_bus;

  if_fetch_queue #(
    .RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO), .IBUF_DEPTH(DEPTH),
    .EBUS_W(16), .EBUS_ADEF(8)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .flush(flush), .flush_target(flush_target),
    .id_allow_in(id_allow_in),
    .ifreg_valid(ifreg_valid), .ifreg_bus(ifreg_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: in-order responses, each at or after its due cycle.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5ee1_0f0f;
  endfunction

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  int          m_drop;
  logic [79:0] m_ibuf[$];
  bit          m_hold;
  logic [31:0] seq_pc;

  // Stimulus knobs.
  bit          k_allow = 1'b1, k_br = 1'b0, k_fl = 1'b0;
  logic [31:0] k_bt = '0, k_ft = '0;
  int          k_ok = 100, k_lat_lo = 1, k_lat_hi = 1;
  int          acc_adef = 0, valid_cnt = 0;

  task automatic step();
    bit          redir, e_req, e_valid, mis;
    logic [31:0] rpc, pc0, head;
    int          np, ni;
    inst_sram_data_ok = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (inst_sram_data_ok) inst_sram_rdata = mem_data(mem_q[0].addr);
    else inst_sram_rdata = $urandom();
    inst_sram_addr_ok = ($urandom_range(0, 99) < k_ok);
    br_taken = k_br; br_target = k_bt; flush = k_fl; flush_target = k_ft;
    id_allow_in = k_allow;
    #4;
    redir   = k_fl | k_br;
    rpc     = k_fl ? k_ft : k_bt;
    np      = m_pend.size();
    ni      = m_ibuf.size();
    pc0     = m_pc;
    mis     = m_pc[1:0] != 2'b00;
    e_req   = !redir && !m_hold && !mis && (np + m_drop < MAXO) && (ni + np < DEPTH);
    e_valid = (ni != 0) && !redir;
    chk("req", inst_sram_req, e_req);
    chk("addr", inst_sram_addr, m_pc);
    chk("valid", ifreg_valid, e_valid);
    if (e_valid) chk("bus", ifreg_bus, m_ibuf[0]);
    if (ifreg_valid) valid_cnt++;
    if (ifreg_valid && k_allow) begin
      chk("seq_pc", ifreg_bus[31:0], seq_pc);
      if (ifreg_bus[79:64] == ADEF_VEC) begin
        acc_adef++;
        chk("adef_inst", ifreg_bus[63:32], 32'h0);
      end else begin
        chk("seq_inst", ifreg_bus[63:32], mem_data(ifreg_bus[31:0]));
      end
      seq_pc = seq_pc + 32'd4;
    end
    if (e_req && inst_sram_addr_ok) begin
      m_pend.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (e_valid && k_allow) void'(m_ibuf.pop_front());
    if (inst_sram_data_ok) begin
      if (m_drop > 0) m_drop--;
      else if (np > 0) begin
        head = m_pend.pop_front();
        m_ibuf.push_back({16'h0, inst_sram_rdata, head});
      end
    end
    if (mis && !m_hold && np == 0 && ni < DEPTH) begin
      m_ibuf.push_back({ADEF_VEC, 32'h0, pc0});
      m_hold = 1'b1;
    end
    if (redir) begin
      m_pc = rpc;
      m_drop += m_pend.size();
      m_pend.delete();
      m_ibuf.delete();
      m_hold = 1'b0;
      seq_pc = rpc;
    end
    if (inst_sram_data_ok) void'(mem_q.pop_front());
    if (inst_sram_req && inst_sram_addr_ok)
      mem_q.push_back('{inst_sram_addr, cyc + int'($urandom_range(k_lat_lo, k_lat_hi))});
    @(posedge clk); #1;
    cyc++;
    k_br = 1'b0;
    k_fl = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    br_taken = 1'b0; flush = 1'b0; id_allow_in = 1'b0;
    #4;
    chk("req_in_reset", inst_sram_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_q.delete();
    m_pc = RESET_PC; m_pend.delete(); m_drop = 0; m_ibuf.delete(); m_hold = 1'b0;
    seq_pc = RESET_PC;
    cyc++;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = RESET_PC + ($urandom_range(0, 63) << 2);
    if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  typedef struct {
    logic aok, dok; logic [31:0] rdata;
    logic br; logic [31:0] bt; logic fl; logic [31:0] ft; logic allow;
    logic ereq; logic [31:0] eaddr; logic evalid; logic [79:0] ebus;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic aok, input logic dok, input logic [31:0] rdata,
                              input logic br, input logic [31:0] bt, input logic fl,
                              input logic [31:0] ft, input logic allow, input logic ereq,
                              input logic [31:0] eaddr, input logic evalid, input logic [79:0] ebus);
    vec_t r;
    r.aok = aok; r.dok = dok; r.rdata = rdata; r.br = br; r.bt = bt; r.fl = fl; r.ft = ft;
    r.allow = allow; r.ereq = ereq; r.eaddr = eaddr; r.evalid = evalid; r.ebus = ebus;
    vt.push_back(r);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    br_taken = 1'b0; br_target = '0; flush = 1'b0; flush_target = '0; id_allow_in = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // aok dok rdata  br bt  fl ft  allow | req addr valid bus
    add(0, 1, 32'hdeadbeef, 0, 0, 0, 0, 1,  1, 32'h1c000000, 0, '0);
    add(1, 0, 0, 0, 0, 0, 0, 1,              1, 32'h1c000000, 0, '0);
    add(1, 0, 0, 0, 0, 0, 0, 1,              1, 32'h1c000004, 0, '0);
    add(1, 1, 32'h11111111, 0, 0, 0, 0, 1,   0, 32'h1c000008, 0, '0);
    add(1, 1, 32'h22222222, 0, 0, 0, 0, 0,   1, 32'h1c000008, 1, {16'h0, 32'h11111111, 32'h1c000000});
    add(0, 0, 0, 1, 32'h1c000100, 0, 0, 1,   0, 32'h1c00000c, 0, '0);
    add(1, 1, 32'h33333333, 0, 0, 0, 0, 1,   1, 32'h1c000100, 0, '0);
    add(0, 1, 32'h44444444, 0, 0, 0, 0, 1,   1, 32'h1c000104, 0, '0);
    add(0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h1c000104, 1, {16'h0, 32'h44444444, 32'h1c000100});
    add(0, 0, 0, 1, 32'h1c000200, 1, 32'h1c000002, 1, 0, 32'h1c000104, 0, '0);
    add(0, 0, 0, 0, 0, 0, 0, 1,              0, 32'h1c000002, 0, '0);
    add(0, 0, 0, 0, 0, 0, 0, 1,              0, 32'h1c000002, 1, {ADEF_VEC, 32'h0, 32'h1c000002});
    add(0, 0, 0, 0, 0, 0, 0, 1,              0, 32'h1c000002, 0, '0);
    add(0, 0, 0, 0, 0, 1, 32'h1c000000, 1,   0, 32'h1c000002, 0, '0);
    add(0, 0, 0, 0, 0, 0, 0, 1,              1, 32'h1c000000, 0, '0);

    foreach (vt[i]) begin
      inst_sram_addr_ok = vt[i].aok; inst_sram_data_ok = vt[i].dok; inst_sram_rdata = vt[i].rdata;
      br_taken = vt[i].br; br_target = vt[i].bt; flush = vt[i].fl; flush_target = vt[i].ft;
      id_allow_in = vt[i].allow;
      #4;
      chk($sformatf("t%0d_req", i), inst_sram_req, vt[i].ereq);
      chk($sformatf("t%0d_addr", i), inst_sram_addr, vt[i].eaddr);
      chk($sformatf("t%0d_valid", i), ifreg_valid, vt[i].evalid);
      if (vt[i].evalid) chk($sformatf("t%0d_bus", i), ifreg_bus, vt[i].ebus);
      @(posedge clk); #1;
      cyc++;
    end

    // Zero-wait memory: one instruction per cycle once the pipe is primed.
    do_reset();
    k_ok = 100; k_lat_lo = 1; k_lat_hi = 1; k_allow = 1'b1;
    repeat (4) step();
    valid_cnt = 0;
    repeat (12) step();
    chk("zero_wait_throughput", 80'(valid_cnt), 80'd12);

    // ID stall: buffer fills, requests stop, nothing lost on release.
    k_allow = 1'b0;
    repeat (10) step();
    chk("stall_req_low", inst_sram_req, 1'b0);
    chk("stall_valid_held", ifreg_valid, 1'b1);
    k_allow = 1'b1;
    repeat (12) step();

    // Branch with two requests in flight at latency 3.
    k_lat_lo = 3; k_lat_hi = 3;
    repeat (6) step();
    k_br = 1'b1; k_bt = 32'h1c000100;
    step();
    repeat (12) step();

    // Flush wins over a simultaneous branch.
    k_lat_lo = 1; k_lat_hi = 1;
    k_fl = 1'b1; k_ft = 32'h1c008000; k_br = 1'b1; k_bt = 32'h1c000200;
    step();
    repeat (10) step();

    // Misaligned branch target: single ADEF entry, then stall until flush.
    k_br = 1'b1; k_bt = 32'h1c000102;
    step();
    acc_adef = 0;
    repeat (8) step();
    chk("adef_once", 80'(acc_adef), 80'd1);
    chk("adef_stall_req", inst_sram_req, 1'b0);
    k_fl = 1'b1; k_ft = 32'h1c000000;
    step();
    repeat (8) step();

    // Reset mid-operation with responses pending and a partly full buffer.
    k_lat_lo = 3; k_lat_hi = 3; k_allow = 1'b0;
    repeat (5) step();
    do_reset();
    id_allow_in = 1'b0;
    #1;
    chk("post_reset_valid", ifreg_valid, 1'b0);
    chk("post_reset_req", inst_sram_req, 1'b1);
    chk("post_reset_addr", inst_sram_addr, RESET_PC);
    k_allow = 1'b1;
    repeat (10) step();

    // Randomized traffic.
    do_reset();
    for (int r = 0; r < 3000; r++) begin
      if (r % 250 == 0) begin
        k_ok = $urandom_range(30, 100);
        k_lat_lo = 1;
        k_lat_hi = $urandom_range(1, 5);
      end
      k_allow = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin k_br = 1'b1; k_bt = rand_tgt(); end
      if ($urandom_range(0, 39) == 0) begin k_fl = 1'b1; k_ft = rand_tgt(); end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end for the pipelined CPU. It replaces the single-outstanding pre-IF/IF pair with three parts: a fetch-PC generator, a pending-request tracker allowing up to `MAX_OUTSTANDING` in-flight SRAM-like requests, and an `IBUF_DEPTH` instruction buffer feeding ID. It handles branch and exception/ertn redirects by discarding stale responses, and it raises ADEF through the exception bus.

## Interface
- `RESET_PC`, 32'h1c000000: first fetch address after reset.
- `MAX_OUTSTANDING`, 2: maximum number of requests accepted (`addr_ok`) but not yet answered (`data_ok`); must be ≥1.
- `IBUF_DEPTH`, 4: instruction buffer entries; power of two, ≥2.
- `EBUS_W`, 16: exception bus width.
- `EBUS_ADEF`, 8: bit index of ADEF in the exception bus.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `inst_sram_req` out 1: request valid.
- `inst_sram_wr` out 1: constant 0.
- `inst_sram_size` out 2: constant 2'b10.
- `inst_sram_addr` out 32: equals `fetch_pc`.
- `inst_sram_wstrb` out 4: constant 0.
- `inst_sram_wdata` out 32: constant 0.
- `inst_sram_addr_ok` in 1: request accepted this cycle.
- `inst_sram_data_ok` in 1: response valid this cycle; responses return in order.
- `inst_sram_rdata` in 32: response data.
- `br_taken` in 1, `br_target` in 32: branch redirect from EX.
- `flush` in 1, `flush_target` in 32: exception entry or ertn era from WB; has priority over `br_taken`.
- `id_allow_in` in 1: ID accepts an entry this cycle.
- `ifreg_valid` out 1: entry presented to ID.
- `ifreg_bus` out `EBUS_W`+64: {ebus, inst, pc}.

## Operation
- `redirect = flush | br_taken`. `redirect_pc = flush ? flush_target : br_target`.
- Counters: `pend_cnt` holds the valid pending PCs in an in-order FIFO of depth `MAX_OUTSTANDING`. `drop_cnt` holds the stale responses still owed. Their sum is ≤ `MAX_OUTSTANDING`.
- `inst_sram_req = ~reset & ~redirect & ~adef_hold & fetch_pc[1:0]==0 & (pend_cnt+drop_cnt) < MAX_OUTSTANDING & (ibuf_cnt+pend_cnt) < IBUF_DEPTH`. The second limit is a credit rule, so the buffer can never overflow.
- On `req & addr_ok`: push `fetch_pc` into the pending FIFO and set `fetch_pc += 4`.
- On `data_ok`:
  - If `drop_cnt>0`, decrement it and discard the data.
  - Otherwise pop the pending head and push {ebus=0, rdata, pc} into the ibuf.
  - If both counters are 0, the response is a protocol error: ignore it and change no state.
- ADEF: when `fetch_pc[1:0]!=0`, no request is issued. Once `pend_cnt==0` and the ibuf is not full, push {ebus with only bit `EBUS_ADEF` set, inst=0, pc=fetch_pc} and set `adef_hold`. Fetching then stays stalled until a redirect.
- Redirect cycle, evaluated after `data_ok` consumption:
  - `fetch_pc <= redirect_pc`.
  - `drop_cnt <= drop_cnt_after + pend_cnt_after`.
  - Clear the pending FIFO.
  - Clear the ibuf, including any push made this cycle.
  - Clear `adef_hold`.
- A misaligned `redirect_pc` is legal and yields the ADEF path.
- Output: `ifreg_valid = (ibuf_cnt!=0) & ~redirect`. `ifreg_bus` is the ibuf head. The head pops on `ifreg_valid & id_allow_in`.
- Push and pop in the same cycle are permitted; `ibuf_cnt` is then unchanged.
- Pointers wrap modulo the depth. Counter widths are `$clog2(depth)+1`.

## Timing
- Reset values:
  - `fetch_pc`=RESET_PC.
  - `pend_cnt`=`drop_cnt`=`ibuf_cnt`=0.
  - `adef_hold`=0.
  - Outputs `inst_sram_req`=0, `ifreg_valid`=0, `inst_sram_addr`=RESET_PC.
- `req` may be high in the first cycle after reset deasserts.
- A reset asserted mid-operation discards all state and all in-flight responses. The memory model is reset concurrently.
- `req` is combinational from registered state plus `redirect`, and holds until `addr_ok`. The address is stable while `req` is held.
- Latency: a `data_ok` in cycle N produces `ifreg_valid` in cycle N+1 (registered ibuf, no bypass).
- With a zero-wait memory (`addr_ok`=1, `data_ok` the next cycle) and `MAX_OUTSTANDING`≥2, throughput is one instruction per cycle.
- Redirect is sampled in cycle N. The redirected `req` first appears in N+1. No entry from before the redirect is ever presented after cycle N.

## Test plan
- Reset, then zero-wait memory returning rdata=pc, with `id_allow_in`=1 -> the first request goes to 0x1c000000, ID receives pc 0x1c000000, 0x1c000004, … one per cycle, and ebus=0.
- Hold `id_allow_in`=0 for 10 cycles -> the ibuf fills to 4, `req` drops with `ibuf_cnt+pend_cnt`=4, and no entry is lost or duplicated after release.
- With 2 requests in flight (memory latency 3), pulse `br_taken` with target 0x1c000100 -> the two stale `data_ok`s are discarded and the next `ifreg_valid` carries pc 0x1c000100.
- Assert `flush` (0x1c008000) and `br_taken` (0x1c000200) in the same cycle -> fetch resumes at 0x1c008000.
- Branch to 0x1c000102 -> no `req`. One entry appears with ebus bit 8 set, inst=0, pc=0x1c000102. The block stays stalled until `flush` with target 0x1c000000 resumes fetching.
- Assert `reset` with 2 responses pending and the ibuf holding 3 entries -> the cycle after reset, `ifreg_valid`=0 and all counters are 0.
